// File: rtl/ysyx_23060208_pkg.sv
// Shared IFU definitions: FSM states, reset PC and response codes.
// Imported by every fetch-path module.
package ysyx_23060208_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND_AR = 2'd1,
    S_WAIT_R  = 2'd2,
    S_HOLD    = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY    = 2'b00;

endpackage

// File: rtl/ysyx_23060208_ifu_pc.sv
// Fetch PC register: sequential +4 advance or redirect load.
// A load takes priority over an increment.
module ysyx_23060208_ifu_pc
  import ysyx_23060208_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(IFU_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_pc,
  input  logic                  inc,
  output logic [DATA_WIDTH-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + DATA_WIDTH'(4);
    end
  end

endmodule

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction fetch unit: one outstanding AXI-lite style read,
// holds the fetched word until decode accepts it, handles redirects.
module ysyx_23060208_ifu_fetch
  import ysyx_23060208_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(IFU_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] ifu_araddr,
  output logic                  ifu_arvalid,
  input  logic                  ifu_arready,
  input  logic                  ifu_rvalid,
  input  logic [1:0]            ifu_rresp,
  input  logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic                  ifu_rready,
  output logic                  ifu_to_idu_valid,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_inst,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_pc,
  output logic                  ifu_to_idu_err,
  input  logic                  idu_allowin,
  input  logic                  exu_redirect_valid,
  input  logic [DATA_WIDTH-1:0] exu_redirect_pc
);

  ifu_state_e state, state_n;
  logic kill_r, kill_n;
  logic [DATA_WIDTH-1:0] tgt_r, tgt_n;
  logic [DATA_WIDTH-1:0] inst_r, ipc_r;
  logic err_r;
  logic [DATA_WIDTH-1:0] pc_r, pc_ld_val;
  logic pc_ld, pc_inc, latch, ar_hs;

  ysyx_23060208_ifu_pc #(
    .DATA_WIDTH(DATA_WIDTH),
    .RESET_PC  (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load   (pc_ld),
    .load_pc(pc_ld_val),
    .inc    (pc_inc),
    .pc     (pc_r)
  );

  assign ifu_arvalid = (state == S_SEND_AR);
  assign ifu_araddr  = pc_r;
  assign ifu_rready  = (state == S_WAIT_R);
  assign ar_hs       = ifu_arvalid & ifu_arready;

  assign ifu_to_idu_valid = (state == S_HOLD) & ~exu_redirect_valid;
  assign ifu_to_idu_inst  = inst_r;
  assign ifu_to_idu_pc    = ipc_r;
  assign ifu_to_idu_err   = err_r;

  // In SEND_AR a redirect target parks in tgt_r so araddr stays stable
  always_comb begin
    state_n   = state;
    kill_n    = kill_r;
    tgt_n     = tgt_r;
    latch     = 1'b0;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    pc_ld_val = exu_redirect_pc;
    unique case (state)
      S_IDLE: begin
        state_n = S_SEND_AR;
        pc_ld   = exu_redirect_valid;
      end
      S_SEND_AR: begin
        if (ar_hs) begin
          state_n = S_WAIT_R;
          if (exu_redirect_valid) begin
            pc_ld  = 1'b1;
            kill_n = 1'b1;
          end else if (kill_r) begin
            pc_ld     = 1'b1;
            pc_ld_val = tgt_r;
          end
        end else if (exu_redirect_valid) begin
          kill_n = 1'b1;
          tgt_n  = exu_redirect_pc;
        end
      end
      S_WAIT_R: begin
        pc_ld = exu_redirect_valid;
        if (ifu_rvalid) begin
          if (kill_r || exu_redirect_valid) begin
            kill_n  = 1'b0;
            state_n = S_SEND_AR;
          end else begin
            latch   = 1'b1;
            state_n = S_HOLD;
          end
        end else if (exu_redirect_valid) begin
          kill_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (exu_redirect_valid) begin
          pc_ld   = 1'b1;
          state_n = S_SEND_AR;
        end else if (idu_allowin) begin
          pc_inc  = 1'b1;
          state_n = S_SEND_AR;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      kill_r <= 1'b0;
      tgt_r  <= '0;
      inst_r <= '0;
      ipc_r  <= '0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_n;
      kill_r <= kill_n;
      tgt_r  <= tgt_n;
      if (latch) begin
        inst_r <= ifu_rdata;
        ipc_r  <= pc_r;
        err_r  <= (ifu_rresp != RESP_OKAY);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// Directed cycle-by-cycle bench for the fetch unit.
// Each vector drives one cycle of inputs and checks that cycle's outputs.
module tb_ysyx_23060208_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rready;
  logic        v_out;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        err_out;
  logic        allowin;
  logic        redir;
  logic [31:0] redir_pc;

  int checks = 0;
  int errors = 0;
  int hs = 0;

  always #5 clk = ~clk;

  ysyx_23060208_ifu_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .ifu_araddr        (araddr),
    .ifu_arvalid       (arvalid),
    .ifu_arready       (arready),
    .ifu_rvalid        (rvalid),
    .ifu_rresp         (rresp),
    .ifu_rdata         (rdata),
    .ifu_rready        (rready),
    .ifu_to_idu_valid  (v_out),
    .ifu_to_idu_inst   (inst_out),
    .ifu_to_idu_pc     (pc_out),
    .ifu_to_idu_err    (err_out),
    .idu_allowin       (allowin),
    .exu_redirect_valid(redir),
    .exu_redirect_pc   (redir_pc)
  );

  always @(posedge clk) if (arvalid && arready) hs++;

  typedef struct {
    logic        rst, ar, rv;
    logic [1:0]  rs;
    logic [31:0] rd;
    logic        al, re;
    logic [31:0] rp;
    logic        ea;
    logic [31:0] eadr;
    logic        er, ev;
    logic [31:0] ei, ep;
    logic        ee;
  } vec_t;

  function automatic vec_t mk(
    input logic r, ar, rv, input logic [1:0] rs,
    input logic [31:0] rd, input logic al, re,
    input logic [31:0] rp, input logic ea,
    input logic [31:0] eadr, input logic er, ev,
    input logic [31:0] ei, ep, input logic ee);
    vec_t t;
    t.rst = r; t.ar = ar; t.rv = rv; t.rs = rs;
    t.rd = rd; t.al = al; t.re = re; t.rp = rp;
    t.ea = ea; t.eadr = eadr; t.er = er; t.ev = ev;
    t.ei = ei; t.ep = ep; t.ee = ee;
    return t;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst = t.rst; arready = t.ar; rvalid = t.rv;
    rresp = t.rs; rdata = t.rd; allowin = t.al;
    redir = t.re; redir_pc = t.rp;
    #1;
    chk({tag, ".arvalid"}, 32'(arvalid), 32'(t.ea));
    if (t.ea) chk({tag, ".araddr"}, araddr, t.eadr);
    chk({tag, ".rready"}, 32'(rready), 32'(t.er));
    chk({tag, ".valid"}, 32'(v_out), 32'(t.ev));
    if (t.ev || !t.rst) begin
      chk({tag, ".inst"}, inst_out, t.ei);
      chk({tag, ".pc"}, pc_out, t.ep);
      chk({tag, ".err"}, 32'(err_out), 32'(t.ee));
    end
  endtask

  localparam logic [31:0] B = 32'h8000_0000;
  localparam logic [31:0] Z = 32'h0;

  vec_t tab[$];
  int   hs0;

  initial begin
    rst = 1'b0; arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    rdata = Z; allowin = 1'b0; redir = 1'b0; redir_pc = Z;
    repeat (2) @(posedge clk);

    tab.push_back(mk(0,0,0,0,Z,0,0,Z, 0,Z,0,0,Z,Z,0));
    tab.push_back(mk(1,0,0,0,Z,0,0,Z, 0,Z,0,0,Z,Z,0));
    tab.push_back(mk(1,1,0,0,Z,0,0,Z, 1,B,0,0,Z,Z,0));
    tab.push_back(mk(1,0,1,0,32'h413,0,0,Z, 0,Z,1,0,Z,Z,0));
    for (int i = 0; i < 5; i++)
      tab.push_back(mk(1,0,0,0,Z,0,0,Z, 0,Z,0,1,32'h413,B,0));
    tab.push_back(mk(1,0,0,0,Z,1,0,Z, 0,Z,0,1,32'h413,B,0));
    tab.push_back(mk(1,1,0,0,Z,0,0,Z, 1,B+4,0,0,Z,Z,0));
    tab.push_back(mk(1,0,0,0,Z,0,0,Z, 0,Z,1,0,Z,Z,0));
    tab.push_back(mk(1,0,1,2,32'hDEAD_BEEF,0,0,Z, 0,Z,1,0,Z,Z,0));
    tab.push_back(mk(1,0,0,0,Z,1,0,Z, 0,Z,0,1,32'hDEAD_BEEF,B+4,1));
    tab.push_back(mk(1,1,0,0,Z,0,0,Z, 1,B+8,0,0,Z,Z,0));
    tab.push_back(mk(1,0,1,0,32'h0010_0093,0,0,Z, 0,Z,1,0,Z,Z,0));
    tab.push_back(mk(1,0,0,0,Z,0,0,Z, 0,Z,0,1,32'h0010_0093,B+8,0));
    tab.push_back(mk(1,0,0,0,Z,1,1,B+32'h200, 0,Z,0,0,Z,Z,0));
    tab.push_back(mk(1,1,0,0,Z,0,0,Z, 1,B+32'h200,0,0,Z,Z,0));
    tab.push_back(mk(1,0,0,0,Z,0,1,B+32'h100, 0,Z,1,0,Z,Z,0));
    tab.push_back(mk(1,0,1,0,32'h1111_1111,0,0,Z, 0,Z,1,0,Z,Z,0));
    tab.push_back(mk(1,0,0,0,Z,0,1,B+32'h300, 1,B+32'h100,0,0,Z,Z,0));
    tab.push_back(mk(1,1,0,0,Z,0,0,Z, 1,B+32'h100,0,0,Z,Z,0));
    tab.push_back(mk(1,0,1,0,32'h2222_2222,0,0,Z, 0,Z,1,0,Z,Z,0));
    tab.push_back(mk(1,1,0,0,Z,0,0,Z, 1,B+32'h300,0,0,Z,Z,0));
    tab.push_back(mk(1,0,1,0,32'h3333_3333,0,1,B+32'h400, 0,Z,1,0,Z,Z,0));
    tab.push_back(mk(1,1,0,0,Z,0,0,Z, 1,B+32'h400,0,0,Z,Z,0));
    tab.push_back(mk(1,0,0,0,Z,0,1,B+32'h500, 0,Z,1,0,Z,Z,0));
    tab.push_back(mk(1,0,0,0,Z,0,1,B+32'h600, 0,Z,1,0,Z,Z,0));
    tab.push_back(mk(1,0,1,0,32'h4444_4444,0,0,Z, 0,Z,1,0,Z,Z,0));
    tab.push_back(mk(1,1,0,0,Z,0,0,Z, 1,B+32'h600,0,0,Z,Z,0));
    tab.push_back(mk(1,0,1,0,32'h5555_5555,0,0,Z, 0,Z,1,0,Z,Z,0));
    tab.push_back(mk(1,0,0,0,Z,1,0,Z, 0,Z,0,1,32'h5555_5555,B+32'h600,0));
    tab.push_back(mk(1,0,0,0,Z,0,0,Z, 1,B+32'h604,0,0,Z,Z,0));

    foreach (tab[i]) apply(tab[i], $sformatf("v%0d", i));

    // arready stall: address must hold, exactly one handshake
    hs0 = hs;
    for (int i = 0; i < 3; i++)
      apply(mk(1,0,0,0,Z,0,0,Z, 1,B+32'h604,0,0,Z,Z,0),
            $sformatf("stall%0d", i));
    apply(mk(1,1,0,0,Z,0,0,Z, 1,B+32'h604,0,0,Z,Z,0), "stall_hs");
    apply(mk(1,0,0,0,Z,0,0,Z, 0,Z,1,0,Z,Z,0), "stall_wr");
    chk("single_hs", 32'(hs - hs0), 32'd1);
    apply(mk(1,0,1,0,32'h6666_6666,0,0,Z, 0,Z,1,0,Z,Z,0), "s_rv");

    // wrap at top of address space
    apply(mk(1,0,0,0,Z,0,1,32'hFFFF_FFFC, 0,Z,0,0,Z,Z,0), "w_redir");
    apply(mk(1,1,0,0,Z,0,0,Z, 1,32'hFFFF_FFFC,0,0,Z,Z,0), "w_ar");
    apply(mk(1,0,1,0,32'h7777_7777,0,0,Z, 0,Z,1,0,Z,Z,0), "w_rv");
    apply(mk(1,0,0,0,Z,1,0,Z, 0,Z,0,1,32'h7777_7777,32'hFFFF_FFFC,0),
          "w_hold");
    apply(mk(1,1,0,0,Z,0,0,Z, 1,Z,0,0,Z,Z,0), "w_ar0");

    // reset in WAIT_R abandons the read
    apply(mk(0,0,0,0,Z,0,0,Z, 0,Z,1,0,32'h7777_7777,32'hFFFF_FFFC,0),
          "r_assert");
    apply(mk(1,0,1,0,32'h9999_9999,0,0,Z, 0,Z,0,0,Z,Z,0), "r_idle");
    apply(mk(1,0,0,0,Z,0,0,Z, 1,B,0,0,Z,Z,0), "r_ar");
    apply(mk(1,1,0,0,Z,0,0,Z, 1,B,0,0,Z,Z,0), "r_hs");
    apply(mk(1,0,1,0,32'h0000_0013,0,0,Z, 0,Z,1,0,Z,Z,0), "r_rv");
    apply(mk(1,0,0,0,Z,0,0,Z, 0,Z,0,1,32'h0000_0013,B,0), "r_hold");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
